// File: rtl/gpio_bank_ctrl.sv
// gpio_bank_ctrl: register-programmable GPIO bank for up to 32 pins.
// Drives per-pin output/tristate and conditions the asynchronous inputs.
// The input path is a 2-FF synchronizer followed by edge detection.
// Edges latch into a W1C status register, and one level interrupt is raised.
// Optional feature macro: GPIO_BANK_CTRL_DEBOUNCE_EN. When it is defined,
// each pin gets a stable-sample debounce stage after the synchronizer.
module gpio_bank_ctrl #(
  parameter int          C_NUM_OF_PIN      = 1,
  parameter logic [31:0] C_TRI_DEFAULT     = 32'hFFFF_FFFF,
  parameter int          C_DEBOUNCE_CYCLES = 16
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  input  logic                    wr_en,
  input  logic                    rd_en,
  input  logic [2:0]              addr,
  input  logic [31:0]             wdata,
  output logic [31:0]             rdata,
  output logic                    rd_valid,
  output logic [C_NUM_OF_PIN-1:0] gpio_o,
  output logic [C_NUM_OF_PIN-1:0] gpio_t,
  input  logic [C_NUM_OF_PIN-1:0] gpio_i,
  output logic                    irq
);

  localparam int N = C_NUM_OF_PIN;

  localparam logic [2:0] A_DATA_OUT   = 3'd0;
  localparam logic [2:0] A_TRI        = 3'd1;
  localparam logic [2:0] A_DATA_IN    = 3'd2;
  localparam logic [2:0] A_IRQ_EN     = 3'd3;
  localparam logic [2:0] A_IRQ_POL    = 3'd4;
  localparam logic [2:0] A_IRQ_ANY    = 3'd5;
  localparam logic [2:0] A_IRQ_STATUS = 3'd6;

  // Register fields narrower than 32 bits read back with zeros above bit N-1.
  function automatic logic [31:0] zext(input logic [N-1:0] v);
    logic [31:0] r;
    r        = '0;
    r[N-1:0] = v;
    return r;
  endfunction

  logic [N-1:0] data_out;
  logic [N-1:0] tri_val;
  logic [N-1:0] irq_en;
  logic [N-1:0] irq_pol;
  logic [N-1:0] irq_any;
  logic [N-1:0] irq_status;
  logic [N-1:0] sync1;
  logic [N-1:0] sync2;
  logic [N-1:0] cond;
  logic [N-1:0] prev;
  logic [N-1:0] rise;
  logic [N-1:0] fall;
  logic [N-1:0] edge_hit;
  logic [N-1:0] w1c_mask;
  logic [31:0]  rd_mux;

  // Control registers written by the register port; the pins follow them directly.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      data_out <= '0;
      tri_val  <= C_TRI_DEFAULT[N-1:0];
      irq_en   <= '0;
      irq_pol  <= '0;
      irq_any  <= '0;
    end else if (wr_en) begin
      case (addr)
        A_DATA_OUT: data_out <= wdata[N-1:0];
        A_TRI:      tri_val  <= wdata[N-1:0];
        A_IRQ_EN:   irq_en   <= wdata[N-1:0];
        A_IRQ_POL:  irq_pol  <= wdata[N-1:0];
        A_IRQ_ANY:  irq_any  <= wdata[N-1:0];
        default: ;
      endcase
    end
  end

  assign gpio_o = data_out;
  assign gpio_t = tri_val;

  // Two-flop synchronizer for the asynchronous pin inputs.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= gpio_i;
      sync2 <= sync1;
    end
  end

`ifdef GPIO_BANK_CTRL_DEBOUNCE_EN
  localparam logic [15:0] DB_LAST = 16'(C_DEBOUNCE_CYCLES - 1);

  logic [N-1:0] stable;
  logic [15:0]  db_cnt [N];

  // Per-pin debounce: adopt the synchronized value only after it differs for DB_LAST+1 samples.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      stable <= '0;
      for (int i = 0; i < N; i++) db_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (sync2[i] != stable[i]) begin
          if (db_cnt[i] == DB_LAST) begin
            stable[i] <= sync2[i];
            db_cnt[i] <= '0;
          end else begin
            db_cnt[i] <= db_cnt[i] + 16'd1;
          end
        end else begin
          db_cnt[i] <= '0;
        end
      end
    end
  end

  assign cond = stable;
`else
  assign cond = sync2;
`endif

  // Previous conditioned sample, the reference for edge detection.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) prev <= '0;
    else          prev <= cond;
  end

  // Edge selection: IRQ_ANY takes both edges; otherwise IRQ_POL picks falling (1) or rising (0).
  always_comb begin
    rise     = cond & ~prev;
    fall     = ~cond & prev;
    edge_hit = (irq_any & (rise | fall)) |
               (~irq_any & ~irq_pol & rise) |
               (~irq_any & irq_pol & fall);
    w1c_mask = (wr_en && addr == A_IRQ_STATUS) ? wdata[N-1:0] : '0;
  end

  // Sticky status: W1C clears, a same-cycle edge sets and therefore wins.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) irq_status <= '0;
    else          irq_status <= (irq_status & ~w1c_mask) | edge_hit;
  end

  // Registered level interrupt from enabled status bits.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) irq <= 1'b0;
    else          irq <= |(irq_status & irq_en);
  end

  // Read data selection from current (pre-write) register contents.
  always_comb begin
    rd_mux = '0;
    case (addr)
      A_DATA_OUT:   rd_mux = zext(data_out);
      A_TRI:        rd_mux = zext(tri_val);
      A_DATA_IN:    rd_mux = zext(cond);
      A_IRQ_EN:     rd_mux = zext(irq_en);
      A_IRQ_POL:    rd_mux = zext(irq_pol);
      A_IRQ_ANY:    rd_mux = zext(irq_any);
      A_IRQ_STATUS: rd_mux = zext(irq_status);
      default:      rd_mux = '0;
    endcase
  end

  // Registered read port: one-cycle valid pulse, data held between reads.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      rdata    <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) rdata <= rd_mux;
    end
  end

endmodule

// File: tb/tb_gpio_bank_ctrl.sv
// tb_gpio_bank_ctrl: directed and randomized checks for gpio_bank_ctrl with 8 pins.
module tb_gpio_bank_ctrl;

  localparam int N = 8;

  logic          aclk    = 1'b0;
  logic          aresetn = 1'b0;
  logic          wr_en   = 1'b0;
  logic          rd_en   = 1'b0;
  logic [2:0]    addr    = '0;
  logic [31:0]   wdata   = '0;
  logic [31:0]   rdata;
  logic          rd_valid;
  logic [N-1:0]  gpio_o;
  logic [N-1:0]  gpio_t;
  logic [N-1:0]  gpio_i  = '0;
  logic          irq;

  int errors = 0;
  int checks = 0;

  // Reference model state for the randomized interrupt section.
  logic [N-1:0] hist [$];
  logic [N-1:0] m_st, m_en, m_pol, m_any;

  always #5 aclk = ~aclk;

  gpio_bank_ctrl #(
    .C_NUM_OF_PIN     (N),
    .C_TRI_DEFAULT    (32'hFFFF_FFFF),
    .C_DEBOUNCE_CYCLES(16)
  ) dut (
    .aclk    (aclk),
    .aresetn (aresetn),
    .wr_en   (wr_en),
    .rd_en   (rd_en),
    .addr    (addr),
    .wdata   (wdata),
    .rdata   (rdata),
    .rd_valid(rd_valid),
    .gpio_o  (gpio_o),
    .gpio_t  (gpio_t),
    .gpio_i  (gpio_i),
    .irq     (irq)
  );

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "bench timed out");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    @(negedge aclk);
    wr_en = 1'b1; addr = a; wdata = d;
    @(posedge aclk); #1;
    wr_en = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [2:0] a, input logic [31:0] exp);
    @(negedge aclk);
    rd_en = 1'b1; addr = a;
    @(posedge aclk); #1;
    rd_en = 1'b0;
    chk({tag, "_vld"}, 32'(rd_valid), 32'd1);
    chk(tag, rdata, exp);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge aclk);
    #1;
  endtask

  // One clock of random stimulus; the model applies the edge rules directly
  // to the input history: the edge seen at clock c compares the inputs
  // present two and three clocks earlier.
  task automatic step(input logic [N-1:0] x, input logic [N-1:0] w1c);
    logic          exp_irq;
    logic [N-1:0]  c, p, set;
    @(negedge aclk);
    gpio_i = x;
    wr_en  = (w1c != '0);
    addr   = 3'd6;
    wdata  = ($urandom() & 32'hFFFF_FF00) | {24'b0, w1c};
    @(posedge aclk); #1;
    wr_en  = 1'b0;
    exp_irq = 1'b0;
    for (int i = 0; i < N; i++) if (m_st[i] && m_en[i]) exp_irq = 1'b1;
    hist.push_front(x);
    if (hist.size() > 4) void'(hist.pop_back());
    c = hist[2];
    p = hist[3];
    set = '0;
    for (int i = 0; i < N; i++) begin
      if (m_any[i])      set[i] = (c[i] != p[i]);
      else if (m_pol[i]) set[i] = (!c[i] && p[i]);
      else               set[i] = (c[i] && !p[i]);
    end
    for (int i = 0; i < N; i++) begin
      if (set[i])      m_st[i] = 1'b1;
      else if (w1c[i]) m_st[i] = 1'b0;
    end
    chk("irq_rand", 32'(irq), 32'(exp_irq));
  endtask

  initial begin
    // Reset state
    #12;
    chk("rst_gpio_t", 32'(gpio_t), 32'h0000_00FF);
    chk("rst_gpio_o", 32'(gpio_o), 32'h0);
    chk("rst_irq", 32'(irq), 32'h0);
    chk("rst_rd_valid", 32'(rd_valid), 32'h0);
    chk("rst_rdata", rdata, 32'h0);
    @(negedge aclk);
    aresetn = 1'b1;
    rd_chk("rst_tri", 3'd1, 32'h0000_00FF);
    rd_chk("rst_data_out", 3'd0, 32'h0);
    idle(1);
    chk("rd_valid_pulse", 32'(rd_valid), 32'h0);
    chk("rdata_hold", rdata, 32'h0);

    // Output drive and readback
    wr(3'd1, 32'h0);
    chk("drv_gpio_t", 32'(gpio_t), 32'h0);
    wr(3'd0, 32'h0000_00A5);
    chk("drv_gpio_o", 32'(gpio_o), 32'h0000_00A5);
    wr(3'd0, 32'hFFFF_FFA5);
    rd_chk("data_out_trunc", 3'd0, 32'h0000_00A5);
    rd_chk("reserved", 3'd7, 32'h0);
    wr(3'd7, 32'hFFFF_FFFF);
    rd_chk("reserved_wr", 3'd7, 32'h0);

    // Simultaneous read and write of DATA_OUT returns the old value
    @(negedge aclk);
    wr_en = 1'b1; rd_en = 1'b1; addr = 3'd0; wdata = 32'h0000_003C;
    @(posedge aclk); #1;
    wr_en = 1'b0; rd_en = 1'b0;
    chk("rw_same_old", rdata, 32'h0000_00A5);
    chk("rw_same_pin", 32'(gpio_o), 32'h0000_003C);
    rd_chk("rw_same_new", 3'd0, 32'h0000_003C);
    wr(3'd3, 32'hFFFF_FFFF);
    rd_chk("irq_en_trunc", 3'd3, 32'h0000_00FF);
    wr(3'd3, 32'h0000_0008);

`ifndef GPIO_BANK_CTRL_DEBOUNCE_EN
    // Rising edge on pin 3: status at k+2, irq at k+3
    @(negedge aclk); gpio_i[3] = 1'b1;
    @(posedge aclk);                 // edge k
    @(posedge aclk); #1;             // edge k+1
    chk("rise_irq_k1", 32'(irq), 32'h0);
    @(negedge aclk); rd_en = 1'b1; addr = 3'd6;
    @(posedge aclk); #1;             // edge k+2, rdata shows status before it
    chk("rise_stat_k2", rdata, 32'h0);
    chk("rise_irq_k2", 32'(irq), 32'h0);
    @(posedge aclk); #1;             // edge k+3
    rd_en = 1'b0;
    chk("rise_stat_k3", rdata, 32'h0000_0008);
    chk("rise_irq_k3", 32'(irq), 32'h1);
    rd_chk("rise_stat_noclr", 3'd6, 32'h0000_0008);
    rd_chk("data_in_pin3", 3'd2, 32'h0000_0008);
    wr(3'd6, 32'h0000_0008);
    chk("w1c_irq_same", 32'(irq), 32'h1);
    idle(1);
    chk("w1c_irq_next", 32'(irq), 32'h0);
    rd_chk("w1c_stat", 3'd6, 32'h0);

    // Falling polarity on pin 1
    wr(3'd4, 32'h0000_0002);
    @(negedge aclk); gpio_i[1] = 1'b1;
    idle(4);
    rd_chk("pol_after_rise", 3'd6, 32'h0);
    @(negedge aclk); gpio_i[1] = 1'b0;
    idle(4);
    rd_chk("pol_after_fall", 3'd6, 32'h0000_0002);
    chk("pol_irq_masked", 32'(irq), 32'h0);
    wr(3'd6, 32'h0000_0002);

    // Both edges on pin 1
    wr(3'd5, 32'h0000_0002);
    @(negedge aclk); gpio_i[1] = 1'b1;
    idle(4);
    rd_chk("any_rise", 3'd6, 32'h0000_0002);
    wr(3'd6, 32'h0000_0002);
    rd_chk("any_clr", 3'd6, 32'h0);
    @(negedge aclk); gpio_i[1] = 1'b0;
    idle(4);
    rd_chk("any_fall", 3'd6, 32'h0000_0002);
    wr(3'd6, 32'h0000_0002);

    // Collision on pin 5: W1C in the edge-detect cycle loses to the set
    @(negedge aclk); gpio_i[5] = 1'b1;
    @(posedge aclk);                 // edge k
    @(posedge aclk);                 // edge k+1
    @(negedge aclk); wr_en = 1'b1; addr = 3'd6; wdata = 32'h0000_0020;
    @(posedge aclk); #1;             // edge k+2
    wr_en = 1'b0;
    rd_chk("collision", 3'd6, 32'h0000_0020);
    wr(3'd6, 32'h0);
    rd_chk("w1c_zero", 3'd6, 32'h0000_0020);
    wr(3'd3, 32'h0000_0020);
    idle(2);
    chk("pre_reset_irq", 32'(irq), 32'h1);
`endif

    // Reset in the middle of a read drops the pending valid
    wr(3'd1, 32'h0);
    @(negedge aclk); rd_en = 1'b1; addr = 3'd0;
    @(posedge aclk); #1;
    chk("mid_rd_valid", 32'(rd_valid), 32'h1);
    #2 aresetn = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(rd_valid), 32'h0);
    chk("mid_rst_rdata", rdata, 32'h0);
    chk("mid_rst_irq", 32'(irq), 32'h0);
    chk("mid_rst_gpio_t", 32'(gpio_t), 32'h0000_00FF);
    chk("mid_rst_gpio_o", 32'(gpio_o), 32'h0);
    @(negedge aclk);
    rd_en = 1'b0; gpio_i = '0;
    aresetn = 1'b1;
    idle(6);

`ifndef GPIO_BANK_CTRL_DEBOUNCE_EN
    // Randomized edges and W1C writes against the reference model
    for (int r = 0; r < 4; r++) begin
      m_en  = 8'($urandom);
      m_pol = 8'($urandom);
      m_any = (r == 0) ? 8'h00 : 8'($urandom);
      wr(3'd3, {24'hABCDEF, m_en});
      wr(3'd4, {24'h123456, m_pol});
      wr(3'd5, {24'h0F0F0F, m_any});
      idle(4);
      wr(3'd6, 32'hFFFF_FFFF);
      idle(2);
      m_st = '0;
      hist.delete();
      for (int i = 0; i < 4; i++) hist.push_front(gpio_i);
      for (int i = 0; i < 200; i++) begin
        logic [N-1:0] x, w;
        x = gpio_i;
        if ($urandom_range(0, 2) == 0) x = x ^ 8'($urandom);
        w = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
        step(x, w);
      end
      for (int i = 0; i < 4; i++) step(gpio_i, 8'h00);
      rd_chk("rand_status", 3'd6, {24'b0, m_st});
      rd_chk("rand_data_in", 3'd2, {24'b0, hist[0]});
    end
`else
    // Debounce: a 10-cycle glitch never reaches DATA_IN
    wr(3'd6, 32'hFFFF_FFFF);
    for (int i = 0; i < 30; i++) begin
      @(negedge aclk);
      if (i == 0)  gpio_i[0] = 1'b1;
      if (i == 10) gpio_i[0] = 1'b0;
      rd_en = 1'b1; addr = 3'd2;
      @(posedge aclk); #1;
      if (i > 0) chk("db_glitch", 32'(rdata[0]), 32'h0);
    end
    rd_en = 1'b0;
    rd_chk("db_glitch_stat", 3'd6, 32'h0);
    // A 40-cycle level shows on DATA_IN 18 cycles after the change
    for (int i = 0; i < 40; i++) begin
      @(negedge aclk);
      if (i == 0) gpio_i[0] = 1'b1;
      rd_en = 1'b1; addr = 3'd2;
      @(posedge aclk); #1;
      if (i >= 16 && i <= 20) chk("db_level", 32'(rdata[0]), (i >= 18) ? 32'h1 : 32'h0);
    end
    rd_en = 1'b0;
    rd_chk("db_level_stat", 3'd6, 32'h0000_0001);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/gpio_bank_ctrl.md
Name: gpio_bank_ctrl

Overview:
- Register-programmable GPIO controller for up to 32 pins.
- Sits directly upstream of the pin concatenation stage: drives per-pin output and tristate, and consumes per-pin input.
- Input path: 2-FF synchronizer, edge detection and a latched interrupt status with a single level IRQ output.
- Accessed through a simple single-cycle write / registered-read register port from the AXI-lite shim.

Parameters:
- C_NUM_OF_PIN, 1, number of pins (1..32).
- C_TRI_DEFAULT, 32'hFFFF_FFFF, reset value of TRI (1 = pin is input).
- C_DEBOUNCE_CYCLES, 16, stable-sample count; used only when the debounce feature is compiled in (2..65535).

Ports:
- aclk  in  1  clock.
- aresetn  in  1  reset.
- wr_en  in  1  write strobe.
- rd_en  in  1  read strobe.
- addr  in  3  word address.
- wdata  in  32  write data.
- rdata  out  32  read data.
- rd_valid  out  1  rdata valid, 1 cycle after rd_en.
- gpio_o  out  C_NUM_OF_PIN  output value per pin (to lo_k).
- gpio_t  out  C_NUM_OF_PIN  tristate per pin, 1 = high-Z (to lt_k).
- gpio_i  in  C_NUM_OF_PIN  asynchronous pin input (from li_k).
- irq  out  1  level interrupt.

Interface notes:
- One clock; reset is asynchronous and active-low (aclk, aresetn).
- gpio_i is asynchronous to aclk.

Behaviour:
- Register map (bits at and above C_NUM_OF_PIN read 0; writes to them are ignored):
  - 0 DATA_OUT: RW, reset 0.
  - 1 TRI: RW, reset C_TRI_DEFAULT[N-1:0].
  - 2 DATA_IN: RO, conditioned input.
  - 3 IRQ_EN: RW, reset 0.
  - 4 IRQ_POL: RW, reset 0; 0 = rising edge, 1 = falling edge.
  - 5 IRQ_ANY: RW, reset 0; 1 = both edges, overrides IRQ_POL.
  - 6 IRQ_STATUS: W1C, reset 0.
  - 7 reserved: reads 0, writes ignored.
- Reset values of outputs:
  - rdata = 0, rd_valid = 0, irq = 0.
  - gpio_o = 0.
  - gpio_t = C_TRI_DEFAULT slice.
  - Sync flops and prev-sample register = 0.
- Writes:
  - Take effect at the wr_en edge.
  - gpio_o / gpio_t follow DATA_OUT / TRI registers directly, so the pins change in the cycle after the write edge.
- Reads:
  - rdata and rd_valid are registered 1 cycle after rd_en; rd_valid is a single-cycle pulse per rd_en.
  - rdata holds its value otherwise.
  - Simultaneous read and write of the same address returns the pre-write value.
  - Reads have no side effects; IRQ_STATUS is not cleared by a read.
- Input path:
  - gpio_i passes through sync1 -> sync2; cond = sync2, or the debounce output when compiled in.
  - prev is cond delayed one cycle.
  - Rising edge = cond & ~prev; falling edge = ~cond & prev.
- IRQ_STATUS:
  - A bit is set when a selected edge is detected, regardless of IRQ_EN, so software can poll.
  - Writing 1 clears the bit; writing 0 has no effect.
  - If an edge event and a W1C on the same bit occur in the same cycle, the set wins.
- irq = registered OR over (IRQ_STATUS & IRQ_EN).
- Latency (no debounce):
  - gpio_i toggles before edge k.
  - sync2 and DATA_IN are valid after edge k+1.
  - IRQ_STATUS bit is set at edge k+2.
  - irq asserts at edge k+3.
  - After the W1C edge, irq deasserts on the next edge.
- Output-driven pins (TRI = 0) still run the input path, which gives readback and loopback of the driven value.
- Mid-operation reset:
  - All state returns to reset values asynchronously.
  - Any pending rd_valid is dropped.
  - Pins float to C_TRI_DEFAULT.

Optional Feature:
- Macro: GPIO_BANK_CTRL_DEBOUNCE_EN.
- Defined:
  - Each pin has a 16-bit counter.
  - When sync2 differs from the stable value, the counter increments; any match resets it to 0.
  - When the counter reaches C_DEBOUNCE_CYCLES-1, the stable value takes sync2 and the counter clears.
  - cond = stable value. All edge and IRQ latencies grow by C_DEBOUNCE_CYCLES.
  - Stable value and counters reset to 0.
- Not defined:
  - cond = sync2.
  - No counters are synthesized.
  - C_DEBOUNCE_CYCLES is ignored.

Test Plan:
- Reset check, N=8: read TRI -> 0x000000FF. Read DATA_OUT -> 0; gpio_t = 0xFF; gpio_o = 0; irq = 0.
- Output drive: write TRI = 0x00, then DATA_OUT = 0xA5 -> gpio_t = 0x00 and gpio_o = 0xA5 one cycle after the write. Write 0xFFFF_FFA5 to DATA_OUT -> readback 0x000000A5.
- Rising IRQ on pin 3: IRQ_EN = 0x08, gpio_i[3] goes 0->1 before edge k -> IRQ_STATUS = 0x08 at edge k+2; irq = 1 at edge k+3. Write 0x08 to IRQ_STATUS -> irq = 0 next cycle.
- Polarity:
  - IRQ_POL[1] = 1, pulse gpio_i[1] 0->1->0 (each level held 4 cycles) -> status bit 1 set only after the fall.
  - IRQ_ANY[1] = 1 -> set on the rise, re-set after W1C on the fall.
- Collision: W1C of bit 5 in the same cycle its edge is detected -> IRQ_STATUS[5] remains 1.
- Debounce (macro on, C_DEBOUNCE_CYCLES = 16):
  - 10-cycle glitch on pin 0 -> DATA_IN[0] stays 0, no status.
  - 40-cycle high level -> DATA_IN[0] = 1 exactly 2 + 16 cycles after the input change.
